multicycle_control_unit: RTL

- Upstream control stage for the 32-bit RV32I-subset datapath.
- Latches the fetched instruction and sequences it through FETCH/DECODE/EXEC/MEM/WB.
- Drives every datapath control strobe (pcsrc, alusrc, aluop, mrw, wb, regrw, immgen_ctrl) plus a PC update enable.
- Consumes the datapath's instr and 4-bit ALU status; keeps a retired-instruction counter.

---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/alu_decoder.sv | 39 +++
 rtl/multicycle_control_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32I-subset control path: opcodes, ALU
// operation codes, FSM state encodings and ALU status bit positions.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_t;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_C = 2;
    localparam int STAT_V = 3;

    // Branch condition from funct3 and the ALU flags of rs1 - rs2.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic [3:0] st);
        logic lt;
        lt = st[STAT_N] ^ st[STAT_V];
        case (funct3)
            3'b000:  branch_taken = st[STAT_Z];
            3'b001:  branch_taken = ~st[STAT_Z];
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = ~lt;
            3'b110:  branch_taken = ~st[STAT_C];
            3'b111:  branch_taken = st[STAT_C];
            default: branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from opcode/funct3/funct7[5], with an
// illegal flag for unknown opcodes and reserved branch funct3 codes.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] aluop,
    output logic       illegal
);

    // Map instruction fields onto an ALU operation.
    always_comb begin
        aluop   = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_R, OP_I: begin
                case (funct3)
                    3'b000:  aluop = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  aluop = ALU_SLL;
                    3'b010:  aluop = ALU_SLT;
                    3'b011:  aluop = ALU_SLTU;
                    3'b100:  aluop = ALU_XOR;
                    3'b101:  aluop = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  aluop = ALU_OR;
                    default: aluop = ALU_AND;
                endcase
            end
            OP_LOAD, OP_STORE: aluop = ALU_ADD;
            OP_BRANCH: begin
                aluop   = ALU_SUB;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the RV32I-subset datapath.
//   state  | meaning
//   FETCH  | present PC, capture instruction into ir at end of cycle
//   DECODE | decode ir, trap unknown opcodes to HALT
//   EXEC   | ALU operation; branches resolve and retire here
//   MEM    | load read / store write (store retires here)
//   WB     | register write-back and retire
//   HALT   | illegal instruction seen; frozen until reset
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_IR = 32'h00000013,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic [3:0]       status,
    input  logic             stall,
    output logic             pcsrc,
    output logic             alusrc,
    output logic             wb,
    output logic [3:0]       aluop,
    output logic             mrw,
    output logic             regrw,
    output logic             immgen_ctrl,
    output logic             pc_en,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t      cur, nxt;
    logic [31:0] ir;
    logic [3:0]  dec_aluop;
    logic        dec_illegal;
    logic        is_r, is_i, is_load, is_store, is_branch, active;

    alu_decoder u_alu_decoder (
        .opcode   (ir[6:0]),
        .funct3   (ir[14:12]),
        .funct7_5 (ir[30]),
        .aluop    (dec_aluop),
        .illegal  (dec_illegal)
    );

    assign is_r      = (ir[6:0] == OP_R);
    assign is_i      = (ir[6:0] == OP_I);
    assign is_load   = (ir[6:0] == OP_LOAD);
    assign is_store  = (ir[6:0] == OP_STORE);
    assign is_branch = (ir[6:0] == OP_BRANCH);
    assign active    = (cur == ST_DECODE) || (cur == ST_EXEC) || (cur == ST_MEM) || (cur == ST_WB);
    assign state     = cur;

    // State, instruction register, sticky illegal flag and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= ST_FETCH;
            ir      <= RESET_IR;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            if (!stall) begin
                cur <= nxt;
                if (cur == ST_FETCH)
                    ir <= instr;
                if (cur == ST_DECODE && dec_illegal)
                    illegal <= 1'b1;
            end
            if (pc_en)
                retired <= retired + CNT_W'(1);
        end
    end

    // Next-state sequencing by instruction class.
    always_comb begin
        nxt = cur;
        case (cur)
            ST_FETCH:  nxt = ST_DECODE;
            ST_DECODE: nxt = dec_illegal ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (is_load || is_store) nxt = ST_MEM;
                else if (is_branch)      nxt = ST_FETCH;
                else                     nxt = ST_WB;
            end
            ST_MEM:    nxt = is_load ? ST_WB : ST_FETCH;
            ST_WB:     nxt = ST_FETCH;
            ST_HALT:   nxt = ST_HALT;
            default:   nxt = ST_FETCH;
        endcase
    end

    // Datapath selects and strobes; strobes drop during stall and reset.
    always_comb begin
        pcsrc       = 1'b0;
        alusrc      = 1'b0;
        wb          = 1'b0;
        aluop       = ALU_ADD;
        immgen_ctrl = 1'b0;
        mrw         = 1'b0;
        regrw       = 1'b0;
        pc_en       = 1'b0;
        if (!rst && active) begin
            aluop       = dec_aluop;
            wb          = is_i || is_load || is_store;
            immgen_ctrl = is_store || is_branch;
            alusrc      = is_load && (cur == ST_MEM || cur == ST_WB);
            pcsrc       = is_branch && (cur == ST_EXEC) && branch_taken(ir[14:12], status);
            if (!stall) begin
                regrw = (cur == ST_WB);
                mrw   = is_store && (cur == ST_MEM);
                pc_en = (cur == ST_WB) || (is_store && cur == ST_MEM) ||
                        (is_branch && cur == ST_EXEC);
            end
        end
    end

endmodule
